// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// APB requester. Accepts one single-word command at a time from a local
// valid/ready command port, runs it as an APB SETUP + ACCESS transfer against
// a single slave, and returns read data / error status on a valid/ready
// response port. Slave wait states are honoured through i_pready. An ACCESS
// phase that stays un-ready for TIMEOUT edges is aborted with a timeout error.
//
// Parameters
//   DW       data width of PWDATA / PRDATA
//   AW       address width (APB allows up to 32)
//   TIMEOUT  ACCESS-phase edges with i_pready low before abort (0 = never)
//
// Ports
//   i_clk, i_reset_n          clock, async active-low reset
//   i_cmd_valid / o_cmd_ready command handshake
//   i_cmd_write, i_cmd_addr,  command fields (1 = write)
//   i_cmd_wdata
//   o_rsp_valid / i_rsp_ready response handshake
//   o_rsp_rdata               read data (0 for writes and timeouts)
//   o_rsp_err                 PSLVERR seen or timeout
//   o_rsp_timeout             transfer aborted by timeout
//   o_paddr, o_pwrite, o_psel,
//   o_penable, o_pwdata       APB requester outputs (all registered)
//   i_prdata, i_pready,
//   i_pslverr                 APB completer inputs
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | ready for a command, APB bus idle
//   S_SETUP  | PSEL high, PENABLE low, one cycle
//   S_ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
//   S_RESP   | bus idle, response held until the consumer takes it
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          i_clk,
    input  logic          i_reset_n,

    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_write,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [DW-1:0] i_cmd_wdata,

    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_rdata,
    output logic          o_rsp_err,
    output logic          o_rsp_timeout,

    output logic [AW-1:0] o_paddr,
    output logic          o_pwrite,
    output logic          o_psel,
    output logic          o_penable,
    output logic [DW-1:0] o_pwdata,
    input  logic [DW-1:0] i_prdata,
    input  logic          i_pready,
    input  logic          i_pslverr
);

    // A zero TIMEOUT still gets a one-bit counter so the logic stays legal;
    // it simply saturates and never triggers an abort.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] wait_cnt_q;
    logic          timeout_hit;
    logic          cnt_sat;

    // Only o_cmd_ready is combinational; everything else leaves a flop.
    assign o_cmd_ready = (state_q == S_IDLE);

    // The abort fires on the edge that would take the count to TIMEOUT,
    // i.e. on the TIMEOUT-th low-PREADY ACCESS edge.
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign timeout_hit = (wait_cnt_q == CW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign cnt_sat = (wait_cnt_q == {CW{1'b1}});

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            o_paddr       <= '0;
            o_pwrite      <= 1'b0;
            o_pwdata      <= '0;
            o_psel        <= 1'b0;
            o_penable     <= 1'b0;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        o_paddr    <= i_cmd_addr;
                        o_pwrite   <= i_cmd_write;
                        o_pwdata   <= i_cmd_wdata;
                        o_psel     <= 1'b1;
                        o_penable  <= 1'b0;
                        wait_cnt_q <= '0;
                        state_q    <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    o_penable <= 1'b1;
                    state_q   <= S_ACCESS;
                end

                S_ACCESS: begin
                    // PREADY is checked first so a completion on the abort
                    // edge is reported as a normal transfer.
                    if (i_pready) begin
                        o_rsp_rdata   <= o_pwrite ? '0 : i_prdata;
                        o_rsp_err     <= i_pslverr;
                        o_rsp_timeout <= 1'b0;
                        o_rsp_valid   <= 1'b1;
                        o_psel        <= 1'b0;
                        o_penable     <= 1'b0;
                        state_q       <= S_RESP;
                    end else if (timeout_hit) begin
                        o_rsp_rdata   <= '0;
                        o_rsp_err     <= 1'b1;
                        o_rsp_timeout <= 1'b1;
                        o_rsp_valid   <= 1'b1;
                        o_psel        <= 1'b0;
                        o_penable     <= 1'b0;
                        wait_cnt_q    <= wait_cnt_q + CW'(1);
                        state_q       <= S_RESP;
                    end else if (!cnt_sat) begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end

                S_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q   <= S_IDLE;
                    o_psel    <= 1'b0;
                    o_penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic          i_cmd_write = 1'b0;
    logic [AW-1:0] i_cmd_addr = '0;
    logic [DW-1:0] i_cmd_wdata = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b0;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_err;
    logic          o_rsp_timeout;
    logic [AW-1:0] o_paddr;
    logic          o_pwrite;
    logic          o_psel;
    logic          o_penable;
    logic [DW-1:0] o_pwdata;
    logic [DW-1:0] i_prdata = '0;
    logic          i_pready = 1'b0;
    logic          i_pslverr = 1'b0;

    int checks = 0;
    int failures = 0;

    apb_master #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_write   (i_cmd_write),
        .i_cmd_addr    (i_cmd_addr),
        .i_cmd_wdata   (i_cmd_wdata),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_rdata   (o_rsp_rdata),
        .o_rsp_err     (o_rsp_err),
        .o_rsp_timeout (o_rsp_timeout),
        .o_paddr       (o_paddr),
        .o_pwrite      (o_pwrite),
        .o_psel        (o_psel),
        .o_penable     (o_penable),
        .o_pwdata      (o_pwdata),
        .i_prdata      (i_prdata),
        .i_pready      (i_pready),
        .i_pslverr     (i_pslverr)
    );

    always #5 i_clk = ~i_clk;

    // nwait < 0 means PREADY never rises (timeout case).
    // exp_lat counts the accept edge as 1, up to the edge after which
    // o_rsp_valid is seen high. exp_pen is the number of cycles PENABLE is high.
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nwait;
        logic [31:0] prdata;
        logic        slverr;
        logic        slverr_wait;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_lat;
        int          exp_pen;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int  lat;
        int  pen;
        int  waits;
        bit  done;
        @(negedge i_clk);
        i_cmd_valid = 1'b1;
        i_cmd_write = v.wr;
        i_cmd_addr  = v.addr;
        i_cmd_wdata = v.wdata;
        i_pready    = 1'b0;
        i_pslverr   = 1'b0;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        chk("setup_psel", o_psel, 1);
        chk("setup_penable", o_penable, 0);
        chk("setup_paddr", o_paddr, v.addr);
        chk("setup_pwrite", o_pwrite, v.wr);
        chk("setup_pwdata", o_pwdata, v.wdata);
        chk("setup_cmd_ready", o_cmd_ready, 0);
        lat = 1;
        pen = 0;
        waits = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge i_clk);
            if (o_penable) begin
                if (v.nwait >= 0 && waits >= v.nwait) begin
                    i_pready  = 1'b1;
                    i_prdata  = v.prdata;
                    i_pslverr = v.slverr;
                end else begin
                    i_pready  = 1'b0;
                    i_prdata  = 32'hFFFF_0000 ^ 32'(waits);
                    i_pslverr = v.slverr_wait;
                end
                waits++;
            end else begin
                i_pready  = 1'b0;
                i_pslverr = 1'b0;
            end
            @(posedge i_clk);
            #1;
            lat++;
            if (o_penable) pen++;
            if (o_psel) begin
                chk("access_paddr_hold", o_paddr, v.addr);
                chk("access_pwdata_hold", o_pwdata, v.wdata);
            end
            if (o_rsp_valid) done = 1;
        end
        i_pready  = 1'b0;
        i_pslverr = 1'b0;
        chk("rsp_seen", done, 1);
        chk("latency", lat, v.exp_lat);
        chk("penable_cycles", pen, v.exp_pen);
        chk("rsp_rdata", o_rsp_rdata, v.exp_rdata);
        chk("rsp_err", o_rsp_err, v.exp_err);
        chk("rsp_timeout", o_rsp_timeout, v.exp_to);
        chk("resp_psel", o_psel, 0);
        chk("resp_penable", o_penable, 0);
        chk("resp_cmd_ready", o_cmd_ready, 0);
        chk("paddr_retained", o_paddr, v.addr);
        @(negedge i_clk);
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("hs_rsp_valid", o_rsp_valid, 0);
        chk("hs_cmd_ready", o_cmd_ready, 1);
        chk("hs_paddr_retained", o_paddr, v.addr);
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t rv;
        // wr, addr, wdata, nwait, prdata, slverr, slverr_wait,
        // exp_rdata, exp_err, exp_to, exp_lat, exp_pen
        vecs[0] = '{1'b1, 32'h08, 32'hA5A5_0001, 0, 32'h1111_1111, 1'b0, 1'b0,
                    32'h0, 1'b0, 1'b0, 3, 1};
        vecs[1] = '{1'b0, 32'h0C, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0,
                    32'hDEAD_BEEF, 1'b0, 1'b0, 5, 3};
        vecs[2] = '{1'b1, 32'h0C, 32'h0000_00C0, 0, 32'h2222_2222, 1'b1, 1'b0,
                    32'h0, 1'b1, 1'b0, 3, 1};
        vecs[3] = '{1'b0, 32'h10, 32'h0, -1, 32'h1234_5678, 1'b0, 1'b0,
                    32'h0, 1'b1, 1'b1, 6, 4};
        vecs[4] = '{1'b0, 32'h14, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 1'b0,
                    32'hCAFE_F00D, 1'b0, 1'b0, 6, 4};
        vecs[5] = '{1'b0, 32'h18, 32'hFFFF_FFFF, 1, 32'h1111_2222, 1'b1, 1'b0,
                    32'h1111_2222, 1'b1, 1'b0, 4, 2};
        vecs[6] = '{1'b1, 32'h20, 32'h0BAD_F00D, 2, 32'h3333_3333, 1'b0, 1'b1,
                    32'h0, 1'b0, 1'b0, 5, 3};

        // Reset state
        #12;
        chk("rst_psel", o_psel, 0);
        chk("rst_penable", o_penable, 0);
        chk("rst_paddr", o_paddr, 0);
        chk("rst_pwrite", o_pwrite, 0);
        chk("rst_pwdata", o_pwdata, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_rdata", o_rsp_rdata, 0);
        chk("rst_rsp_err", o_rsp_err, 0);
        chk("rst_rsp_timeout", o_rsp_timeout, 0);
        chk("rst_cmd_ready", o_cmd_ready, 1);
        // A command offered during reset must not be taken.
        i_cmd_valid = 1'b1;
        i_cmd_addr  = 32'h44;
        @(posedge i_clk);
        #1;
        chk("rst_no_accept", o_psel, 0);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_reset_n   = 1'b1;

        for (int k = 0; k < 7; k++) run_xfer(vecs[k]);

        // Response back-pressure
        @(negedge i_clk);
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b0;
        i_cmd_addr  = 32'h30;
        i_cmd_wdata = 32'h0;
        i_pready    = 1'b1;
        i_prdata    = 32'h600D_F00D;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        @(posedge i_clk);
        #1;
        chk("bp_access", o_penable, 1);
        @(posedge i_clk);
        #1;
        chk("bp_rsp_valid", o_rsp_valid, 1);
        chk("bp_rsp_rdata", o_rsp_rdata, 32'h600D_F00D);
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            i_cmd_valid = 1'b1;
            i_cmd_write = 1'b1;
            i_cmd_addr  = 32'h34;
            i_cmd_wdata = 32'h0000_0077;
            i_prdata    = 32'h9999_0000 + 32'(c);
            @(posedge i_clk);
            #1;
            chk("bp_hold_valid", o_rsp_valid, 1);
            chk("bp_hold_rdata", o_rsp_rdata, 32'h600D_F00D);
            chk("bp_hold_err", o_rsp_err, 0);
            chk("bp_cmd_ready", o_cmd_ready, 0);
            chk("bp_no_accept", o_psel, 0);
            chk("bp_paddr", o_paddr, 32'h30);
        end
        @(negedge i_clk);
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("bp_hs_valid", o_rsp_valid, 0);
        chk("bp_hs_no_accept", o_psel, 0);
        chk("bp_hs_cmd_ready", o_cmd_ready, 1);
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        chk("bp_next_psel", o_psel, 1);
        chk("bp_next_paddr", o_paddr, 32'h34);
        chk("bp_next_pwrite", o_pwrite, 1);
        @(posedge i_clk);
        #1;
        chk("bp_next_penable", o_penable, 1);
        @(posedge i_clk);
        #1;
        chk("bp_next_rsp_valid", o_rsp_valid, 1);
        chk("bp_next_rdata", o_rsp_rdata, 0);
        i_pready = 1'b0;
        @(negedge i_clk);
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;

        // Reset in the middle of ACCESS
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b0;
        i_cmd_addr  = 32'h40;
        i_pready    = 1'b0;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        @(posedge i_clk);
        #1;
        chk("mid_penable", o_penable, 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_psel", o_psel, 0);
        chk("mid_rst_penable", o_penable, 0);
        chk("mid_rst_paddr", o_paddr, 0);
        chk("mid_rst_rsp_valid", o_rsp_valid, 0);
        chk("mid_rst_cmd_ready", o_cmd_ready, 1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge i_clk);
            #1;
            chk("post_rst_no_rsp", o_rsp_valid, 0);
            chk("post_rst_idle", o_psel, 0);
        end
        rv = '{1'b0, 32'h00, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b0,
               32'h5555_AAAA, 1'b0, 1'b0, 3, 1};
        run_xfer(rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that converts single-word commands from a local valid/ready command port into APB SETUP/ACCESS transfers, and returns read data and error status on a response port. It is the bus-initiating end of our APB register interface: CPU/DMA glue logic or a test sequencer sits on the command side, and one APB slave sits on the bus side. It issues one transfer at a time, supports slave wait states via PREADY, and aborts with a timeout error if the slave never responds.

## Interface
- DW, 32, data width (PWDATA/PRDATA)
- AW, 32, address width (max 32 per APB)
- TIMEOUT, 16, max ACCESS-phase cycles with PREADY low before abort; 0 disables the timeout
- i_clk  in  1  clock; all logic on rising edge
- i_reset_n  in  1  reset, asynchronous assertion, active-low
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  block can accept a command
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_addr  in  AW  byte address
- i_cmd_wdata  in  DW  write data
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  consumer takes response
- o_rsp_rdata  out  DW  read data (0 for writes and timeouts)
- o_rsp_err  out  1  PSLVERR seen or timeout
- o_rsp_timeout  out  1  transfer aborted by timeout
- o_paddr  out  AW  APB address
- o_pwrite  out  1  APB write
- o_psel  out  1  APB select
- o_penable  out  1  APB enable
- o_pwdata  out  DW  APB write data
- i_prdata  in  DW  APB read data
- i_pready  in  1  APB ready
- i_pslverr  in  1  APB slave error

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: o_cmd_ready = 1 (combinational from state). On i_cmd_valid && o_cmd_ready: latch write/addr/wdata onto o_pwrite/o_paddr/o_pwdata, go to SETUP.
- SETUP: o_psel=1, o_penable=0; unconditionally go to ACCESS.
- ACCESS: o_psel=1, o_penable=1; o_paddr/o_pwrite/o_pwdata held stable. Wait counter increments on each ACCESS edge with i_pready=0.
  - i_pready=1: capture o_rsp_rdata = read ? i_prdata : 0; o_rsp_err = i_pslverr; o_rsp_timeout=0; go to RESP.
  - i_pready=0 and counter reaches TIMEOUT (TIMEOUT≠0): o_rsp_rdata=0, o_rsp_err=1, o_rsp_timeout=1; go to RESP.
  - i_pready=1 on the same edge the timeout would fire: normal completion wins.
- RESP: o_psel=0, o_penable=0, o_rsp_valid=1; response fields held stable until i_rsp_ready=1, then go to IDLE. o_cmd_ready=0 throughout.
- i_pslverr ignored outside the ACCESS edge where i_pready=1.
- Wait counter: $clog2(TIMEOUT+1) bits, cleared on entry to SETUP; never wraps (saturates at abort).
- o_paddr/o_pwdata/o_pwrite retain last values after a transfer (no forced zeroing).

## Timing
- Reset (asynchronous, any cycle, including mid-transfer): state=IDLE, o_psel=0, o_penable=0, o_paddr=0, o_pwrite=0, o_pwdata=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_rsp_timeout=0, counter=0. o_cmd_ready reads 1 once state is IDLE; no command accepted while i_reset_n=0. An aborted transfer produces no response.
- Edge E0 accepts command. After E0: SETUP (psel=1). After E1: ACCESS (penable=1). If i_pready=1 at E2: after E2 psel=penable=0, o_rsp_valid=1. Zero-wait latency: accept to o_rsp_valid = 3 cycles.
- Each low-PREADY edge in ACCESS adds one cycle.
- Timeout: with i_pready stuck low, abort at the TIMEOUT-th ACCESS edge; o_rsp_valid rises TIMEOUT+2 cycles after E0.
- Response handshake at edge Er (o_rsp_valid && i_rsp_ready); o_cmd_ready=1 after Er; next accept earliest at Er+1. Max throughput: one transfer per 4 cycles.
- All APB and response outputs are registered; only o_cmd_ready is combinational from state.

## Test plan
- Write, zero wait: cmd write addr 0x08 data 0xA5A5_0001, i_pready=1 in ACCESS, i_pslverr=0 -> one SETUP, one ACCESS with paddr 0x08/pwdata 0xA5A5_0001/pwrite=1; o_rsp_valid 3 cycles after accept, rdata=0, err=0.
- Read, two wait states: cmd read 0x0C, i_pready low 2 ACCESS cycles then high with i_prdata=0xDEAD_BEEF -> penable high 3 cycles, o_rsp_rdata=0xDEAD_BEEF, err=0, latency 5.
- Slave error: write to 0x0C, i_pready=1, i_pslverr=1 -> o_rsp_err=1, o_rsp_timeout=0.
- Timeout: TIMEOUT=4, i_pready held 0 -> psel drops after 4th ACCESS edge, o_rsp_err=1, o_rsp_timeout=1, rdata=0; repeat with i_pready=1 on that 4th edge -> normal completion.
- Response back-pressure: i_rsp_ready low 5 cycles -> o_rsp_valid and fields stable, o_cmd_ready=0, new i_cmd_valid not accepted; accepted the cycle after handshake.
- Reset mid-ACCESS: assert i_reset_n=0 asynchronously while penable=1 -> psel/penable drop immediately, no response issued; after release a read of 0x00 completes normally.
